// File: rtl/spi_mstr_pkg.sv
// Shared types and derived constants for the parametrised mode-3 SPI master.
// Optional LSB-first support is compiled in with SPI_MSTR_LSB_FIRST_EN.
package spi_mstr_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Divider load {2'b10, all ones} sets the front porch before the first SCLK fall.
  function automatic int fp_load(input int div_w);
    return (32'sd1 <<< (div_w - 32'sd1)) + (32'sd1 <<< (div_w - 32'sd2)) - 32'sd1;
  endfunction

  function automatic int smpl_match(input int div_w);
    return (32'sd1 <<< (div_w - 32'sd1)) - 32'sd1;
  endfunction

  function automatic int shft_match(input int div_w);
    return (32'sd1 <<< div_w) - 32'sd1;
  endfunction

  function automatic int cnt_w(input int data_w);
    return $clog2(data_w + 32'sd1);
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider for the SPI master: free-running counter while active,
// producing SCLK and the sample/shift strobes one clk ahead of each SCLK edge.
module spi_sclk_gen
  import spi_mstr_pkg::*;
#(
  parameter int DIV_W = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic run_i,
  output logic sclk_o,
  output logic smpl_o,
  output logic shft_o
);

  localparam logic [DIV_W-1:0] LOAD_VAL = DIV_W'(fp_load(DIV_W));
  localparam logic [DIV_W-1:0] SMPL_VAL = DIV_W'(smpl_match(DIV_W));
  localparam logic [DIV_W-1:0] SHFT_VAL = DIV_W'(shft_match(DIV_W));

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  always_comb begin
    div_d = div_q;
    if (load_i) begin
      div_d = LOAD_VAL;
    end else if (run_i) begin
      div_d = div_q + DIV_W'(1);
    end else begin
      div_d = div_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // SCLK is held high whenever the master is not mid-frame.
  assign sclk_o = run_i ? div_q[DIV_W-1] : 1'b1;
  assign smpl_o = run_i && (div_q == SMPL_VAL);
  assign shft_o = run_i && (div_q == SHFT_VAL);

endmodule

// File: rtl/spi_mstr_param.sv
// Parametrised SPI master, mode 3, full duplex; one frame per accepted wrt.
// Define SPI_MSTR_LSB_FIRST_EN to add the lsb_first input (per-frame bit order).
module spi_mstr_param
  import spi_mstr_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIV_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt,
  input  logic [DATA_W-1:0] cmd,
  output logic              done,
  output logic              busy,
  output logic [DATA_W-1:0] rd_data,
  output logic              SS_n,
  output logic              SCLK,
  output logic              MOSI,
`ifdef SPI_MSTR_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  input  logic              MISO
);

  localparam int               CNT_W    = cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  state_e            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              miso_smpl_q;
  logic              done_q;
  logic              busy_q;
  logic              ss_n_q;
  logic              lsb_q;
  logic              lsb_in;
  logic              run;
  logic              accept;
  logic              smpl;
  logic              shft;

`ifdef SPI_MSTR_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  assign run    = (state_q == ACTIVE);
  assign accept = (state_q == IDLE) && wrt;

  spi_sclk_gen #(
    .DIV_W (DIV_W)
  ) u_sclk_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept),
    .run_i  (run),
    .sclk_o (SCLK),
    .smpl_o (smpl),
    .shft_o (shft)
  );

  always_comb begin
    if (lsb_q) begin
      shift_d = {miso_smpl_q, shift_q[DATA_W-1:1]};
    end else begin
      shift_d = {shift_q[DATA_W-2:0], miso_smpl_q};
    end
  end

  // The first SCLK fall (bit_cnt still 0) carries no shift: MOSI already holds the first bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      miso_smpl_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ss_n_q      <= 1'b1;
      lsb_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wrt) begin
            shift_q   <= cmd;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
            ss_n_q    <= 1'b0;
            lsb_q     <= lsb_in;
            state_q   <= ACTIVE;
          end else begin
            ss_n_q <= 1'b1;
          end
        end
        ACTIVE: begin
          if (smpl) begin
            miso_smpl_q <= MISO;
            bit_cnt_q   <= bit_cnt_q + CNT_W'(1);
          end
          if (shft && (bit_cnt_q != '0)) begin
            shift_q <= shift_d;
            if (bit_cnt_q == LAST_CNT) begin
              ss_n_q  <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          ss_n_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign done    = done_q;
  assign busy    = busy_q;
  assign SS_n    = ss_n_q;
  assign rd_data = shift_q;
  assign MOSI    = lsb_q ? shift_q[0] : shift_q[DATA_W-1];

endmodule
